// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between IF fetch and MEM load/store; MEM first, then fetch.
// Optional wait-for-ack timeout with sticky bus error is built when UMA_TIMEOUT_EN is defined.
module unified_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  input  logic              i_dReq,
  input  logic              i_dWe,
  input  logic [ADDR_W-1:0] i_dAddr,
  input  logic [DATA_W-1:0] i_dWdata,
  input  logic [1:0]        i_dSize,
  output logic [DATA_W-1:0] o_inst,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_stall,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWdata,
  output logic [1:0]        o_memSize,
  input  logic              i_memAck,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic              o_busError
);

  localparam logic [0:0]        START    = 1'b0;
  localparam logic [0:0]        FETCH    = 1'b1;
  localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013);

  logic [0:0]        state_q;
  logic [DATA_W-1:0] rd_buf;
  logic              data_phase;
  logic              forced;
  logic              done;

  // The data access is decided only in START; FETCH always issues the fetch.
  assign data_phase = (state_q == START) && i_dReq;

  // Request is combinationally killed while reset is held, so a late ack cannot complete anything.
  assign o_memReq   = reset_x;
  assign o_memWe    = data_phase && i_dWe;
  assign o_memAddr  = data_phase ? i_dAddr : i_fetchAddr;
  assign o_memWdata = i_dWdata;
  assign o_memSize  = data_phase ? i_dSize : 2'b10;

  assign done       = o_memReq && (i_memAck || forced);
  assign o_stall    = ~(~data_phase && done);
  assign o_inst     = forced ? NOP_INST : i_memRdata;
  assign o_readData = rd_buf;

`ifdef UMA_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  // A real ack in the timeout cycle wins over the forced completion.
  assign forced     = ~i_memAck && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign o_busError = bus_err_q;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (done) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (forced) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  assign forced     = 1'b0;
  assign o_busError = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= START;
      rd_buf  <= '0;
    end else if (done) begin
      if (data_phase) begin
        if (!i_dWe) begin
          rd_buf <= forced ? '0 : i_memRdata;
        end
        state_q <= FETCH;
      end else begin
        state_q <= START;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory transactions queued at stimulus, checked at each ack.
module tb_unified_mem_arbiter;

  typedef struct {
    logic        we;
    logic        is_fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          lat;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_x;
  logic [31:0] i_fetchAddr;
  logic        i_dReq;
  logic        i_dWe;
  logic [31:0] i_dAddr;
  logic [31:0] i_dWdata;
  logic [1:0]  i_dSize;
  logic [31:0] o_inst;
  logic [31:0] o_readData;
  logic        o_stall;
  logic        o_memReq;
  logic        o_memWe;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic [1:0]  o_memSize;
  logic        i_memAck;
  logic [31:0] i_memRdata;
  logic        o_busError;

  txn_t        exp_q[$];
  logic [31:0] rd_model = 32'h0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_x(reset_x), .i_fetchAddr(i_fetchAddr), .i_dReq(i_dReq), .i_dWe(i_dWe),
    .i_dAddr(i_dAddr), .i_dWdata(i_dWdata), .i_dSize(i_dSize), .o_inst(o_inst),
    .o_readData(o_readData), .o_stall(o_stall), .o_memReq(o_memReq), .o_memWe(o_memWe),
    .o_memAddr(o_memAddr), .o_memWdata(o_memWdata), .o_memSize(o_memSize),
    .i_memAck(i_memAck), .i_memRdata(i_memRdata), .o_busError(o_busError)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one pipeline advance from a negedge and plays memory with the given ack latencies.
  task automatic run_instr(input logic dreq, input logic we, input logic [31:0] daddr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic [31:0] pc,
                           input int lat_d, input int lat_f, input logic drop_dreq);
    txn_t t;
    txn_t h;
    int   cycles;
    int   w;
    int   exp_cycles;
    logic done;
    i_dReq = dreq; i_dWe = we; i_dAddr = daddr; i_dWdata = wdata; i_dSize = size;
    i_fetchAddr = pc;
    exp_cycles = lat_f + 1;
    if (dreq) begin
      t = '{we, 1'b0, daddr, wdata, size, lat_d};
      exp_q.push_back(t);
      exp_cycles += lat_d + 1;
    end
    t = '{1'b0, 1'b1, pc, 32'h0, 2'b10, lat_f};
    exp_q.push_back(t);
    cycles = 0; w = 0; done = 1'b0;
    while (!done && cycles < 64) begin
      h = exp_q[0];
      i_memAck   = (w >= h.lat);
      i_memRdata = i_memAck ? mem_model(h.addr) : $urandom;
      #1;
      if (i_memAck) begin
        void'(exp_q.pop_front());
        check_val("mem_we", 32'(o_memWe), 32'(h.we));
        check_val("mem_addr", o_memAddr, h.addr);
        check_val("mem_size", 32'(o_memSize), 32'(h.size));
        if (h.we) check_val("mem_wdata", o_memWdata, h.wdata);
        if (h.is_fetch) begin
          check_val("stall_release", 32'(o_stall), 32'h0);
          check_val("inst", o_inst, mem_model(pc));
          check_val("read_data", o_readData, rd_model);
          done = 1'b1;
        end else begin
          check_val("stall_data_ack", 32'(o_stall), 32'h1);
          if (!h.we) rd_model = mem_model(h.addr);
        end
        w = 0;
      end else begin
        check_val("stall_wait", 32'(o_stall), 32'h1);
        w++;
      end
      cycles++;
      @(negedge clk);
      if (drop_dreq && !h.is_fetch && i_memAck) i_dReq = 1'b0;
    end
    i_memAck = 1'b0;
    check_val("cycles", 32'(cycles), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_x = 1'b0; i_fetchAddr = 32'h0; i_dReq = 1'b0; i_dWe = 1'b0; i_dAddr = 32'h0;
    i_dWdata = 32'h0; i_dSize = 2'b00; i_memAck = 1'b0; i_memRdata = 32'h0;
    #1;
    check_val("rst_memreq", 32'(o_memReq), 32'h0);
    check_val("rst_readdata", o_readData, 32'h0);
    check_val("rst_buserr", 32'(o_busError), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_x = 1'b1;

    // Fetch-only stream, single-cycle acks
    for (int k = 0; k < 4; k++) run_instr(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h10000 + 32'(4 * k), 0, 0, 1'b0);
    // Load then fetch, two wait cycles each
    run_instr(1'b1, 1'b0, 32'h2000, 32'h0, 2'b10, 32'h10004, 2, 2, 1'b0);
    // Byte store: rdBuf must keep the earlier load data
    run_instr(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 2'b00, 32'h10008, 1, 0, 1'b0);
    // dReq drops while in FETCH
    run_instr(1'b1, 1'b0, 32'h3000, 32'h0, 2'b01, 32'h1000C, 0, 3, 1'b1);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h10010, 1, 1, 1'b0);

    // Reset while FETCH waits; a late ack during reset must be ignored
    i_dReq = 1'b1; i_dWe = 1'b0; i_dAddr = 32'h4000; i_dSize = 2'b10; i_fetchAddr = 32'h10014;
    i_memAck = 1'b1; i_memRdata = mem_model(32'h4000);
    #1;
    check_val("rst_mid_stall", 32'(o_stall), 32'h1);
    @(negedge clk);
    i_memAck = 1'b0;
    #1;
    check_val("rst_mid_fetch_addr", o_memAddr, 32'h10014);
    @(negedge clk);
    reset_x = 1'b0; i_memAck = 1'b1;
    #1;
    check_val("rst_mid_memreq", 32'(o_memReq), 32'h0);
    check_val("rst_mid_readdata", o_readData, 32'h0);
    @(negedge clk);
    i_memAck = 1'b0; reset_x = 1'b1; rd_model = 32'h0; exp_q.delete();
    #1;
    check_val("post_rst_addr", o_memAddr, 32'h4000);
    check_val("post_rst_memreq", 32'(o_memReq), 32'h1);
    @(negedge clk);
    run_instr(1'b1, 1'b0, 32'h4000, 32'h0, 2'b10, 32'h10014, 0, 1, 1'b0);

`ifdef UMA_TIMEOUT_EN
    i_dReq = 1'b0; i_fetchAddr = 32'h10020; i_memAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("to_stall", 32'(o_stall), 32'h1);
      @(negedge clk);
    end
    #1;
    check_val("to_release", 32'(o_stall), 32'h0);
    check_val("to_nop", o_inst, 32'h0000_0013);
    @(negedge clk);
    #1;
    check_val("to_buserr", 32'(o_busError), 32'h1);
    @(negedge clk);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h10024, 0, 0, 1'b0);
    check_val("to_buserr_sticky", 32'(o_busError), 32'h1);
`else
    check_val("buserr_tied", 32'(o_busError), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
